// File: rtl/aes_block_sequencer.sv
// rtl/aes_block_sequencer.sv - splits a message into cipher blocks and runs them through one core
// Optional CBC chaining is built only when AES_SEQ_CBC_EN is defined.
module aes_block_sequencer #(
  parameter int NUM_BLK = 2,
  parameter int BLK_W   = 128,
  parameter int KEY_W   = 128
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_dec,
  input  logic                     req_cbc,
  input  logic [KEY_W-1:0]         req_key,
  input  logic [BLK_W-1:0]         req_iv,
  input  logic [NUM_BLK*BLK_W-1:0] req_text,
  output logic                     core_valid,
  input  logic                     core_ready,
  output logic                     core_dec,
  output logic [KEY_W-1:0]         core_key,
  output logic [BLK_W-1:0]         core_din,
  input  logic                     core_rsp_valid,
  input  logic [BLK_W-1:0]         core_dout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [NUM_BLK*BLK_W-1:0] rsp_data,
  output logic                     busy
);

  localparam int IDX_W = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;
  localparam int MSG_W = NUM_BLK * BLK_W;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic               dec_q;
  logic [KEY_W-1:0]   key_q;
  logic [MSG_W-1:0]   text_q;
  logic [BLK_W-1:0]   blk_in;
  logic [BLK_W-1:0]   result;
  logic               last_blk;
  logic               accept;
  logic               blk_done;

  // Block 0 sits in the most significant slice of the message.
  assign blk_in   = text_q[(NUM_BLK - 1 - int'(idx_q)) * BLK_W +: BLK_W];
  assign last_blk = (idx_q == IDX_W'(NUM_BLK - 1));
  assign accept   = (state_q == IDLE) && req_valid;
  assign blk_done = (state_q == WAIT) && core_rsp_valid;
  assign core_dec = dec_q;
  assign core_key = key_q;

`ifdef AES_SEQ_CBC_EN
  logic               cbc_q;
  logic [BLK_W-1:0]   prev_q;

  assign core_din = (cbc_q && !dec_q) ? (blk_in ^ prev_q) : blk_in;
  assign result   = (cbc_q && dec_q) ? (core_dout ^ prev_q) : core_dout;

  // prev always tracks the ciphertext of the block just completed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cbc_q  <= 1'b0;
      prev_q <= '0;
    end else if (accept) begin
      cbc_q  <= req_cbc;
      prev_q <= req_iv;
    end else if (blk_done) begin
      prev_q <= dec_q ? blk_in : core_dout;
    end
  end
`else
  logic unused_cbc;

  assign core_din   = blk_in;
  assign result     = core_dout;
  assign unused_cbc = ^{req_cbc, req_iv};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    core_valid = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (state_q)
      IDLE: begin
        req_ready = rst_n;
        busy      = 1'b0;
        if (req_valid) state_d = ISSUE;
      end
      ISSUE: begin
        core_valid = 1'b1;
        if (core_ready) state_d = WAIT;
      end
      WAIT: begin
        if (core_rsp_valid) state_d = last_blk ? DONE : ISSUE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      dec_q    <= 1'b0;
      key_q    <= '0;
      text_q   <= '0;
      rsp_data <= '0;
    end else begin
      if (accept) begin
        idx_q  <= '0;
        dec_q  <= req_dec;
        key_q  <= req_key;
        text_q <= req_text;
      end
      if (blk_done) begin
        rsp_data[(NUM_BLK - 1 - int'(idx_q)) * BLK_W +: BLK_W] <= result;
        if (!last_blk) idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_aes_block_sequencer.sv
// tb/tb_aes_block_sequencer.sv - scoreboard bench for aes_block_sequencer with a toy cipher core
module tb_aes_block_sequencer;

  localparam int NB = 3;
  localparam int BW = 128;
  localparam int KW = 128;
  localparam int MW = NB * BW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_dec, req_cbc;
  logic [KW-1:0] req_key;
  logic [BW-1:0] req_iv;
  logic [MW-1:0] req_text;
  logic          core_valid, core_ready, core_dec;
  logic [KW-1:0] core_key;
  logic [BW-1:0] core_din;
  logic          core_rsp_valid;
  logic [BW-1:0] core_dout;
  logic          rsp_valid, rsp_ready;
  logic [MW-1:0] rsp_data;
  logic          busy;

  aes_block_sequencer #(.NUM_BLK(NB), .BLK_W(BW), .KEY_W(KW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_dec(req_dec), .req_cbc(req_cbc),
    .req_key(req_key), .req_iv(req_iv), .req_text(req_text),
    .core_valid(core_valid), .core_ready(core_ready), .core_dec(core_dec),
    .core_key(core_key), .core_din(core_din),
    .core_rsp_valid(core_rsp_valid), .core_dout(core_dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [MW-1:0] exp_q[$];

  bit zero_wait = 0, stall3 = 0, spur_en = 0;
  int dly_force = -1;
  bit rsp_force_en = 1, rsp_force = 1;
  logic [KW-1:0] cur_key;
  logic          cur_dec;
  int hs_count = 0;

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] rand_blk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [MW-1:0] rand_msg();
    logic [MW-1:0] m;
    for (int i = 0; i < NB; i++) m[i*BW +: BW] = rand_blk();
    return m;
  endfunction

  // Toy invertible block cipher standing in for AES on the core port.
  function automatic logic [BW-1:0] toy_enc(input logic [KW-1:0] k, input logic [BW-1:0] x);
    logic [BW-1:0] t;
    t = x ^ k;
    return {t[BW-6:0], t[BW-1:BW-5]};
  endfunction

  function automatic logic [BW-1:0] toy_dec(input logic [KW-1:0] k, input logic [BW-1:0] y);
    logic [BW-1:0] t;
    t = {y[4:0], y[BW-1:5]};
    return t ^ k;
  endfunction

  function automatic logic [MW-1:0] model(input bit dec, input bit cbc, input logic [KW-1:0] key,
                                          input logic [BW-1:0] iv, input logic [MW-1:0] text);
    logic [MW-1:0] out;
    logic [BW-1:0] prev, p, r;
    bit use_cbc;
`ifdef AES_SEQ_CBC_EN
    use_cbc = cbc;
`else
    use_cbc = 1'b0;
`endif
    prev = iv;
    for (int i = 0; i < NB; i++) begin
      p = text[(NB-1-i)*BW +: BW];
      if (!dec) begin
        r = toy_enc(key, use_cbc ? (p ^ prev) : p);
        prev = r;
      end else begin
        r = toy_dec(key, p);
        if (use_cbc) r = r ^ prev;
        prev = p;
      end
      out[(NB-1-i)*BW +: BW] = r;
    end
    return out;
  endfunction

  // Core responder: drives core_ready, returns results, injects stray pulses.
  initial begin
    bit pend = 0, was_stalled = 0;
    int pend_dly = 0, stall_cnt = 0;
    logic [BW-1:0] pend_dout, held_din;
    core_ready = 0; core_rsp_valid = 0; core_dout = '0;
    forever begin
      @(posedge clk); #1;
      core_rsp_valid = 0;
      if (pend) begin
        if (pend_dly == 0) begin
          core_rsp_valid = 1; core_dout = pend_dout; pend = 0;
        end else pend_dly--;
      end else if (spur_en && $urandom_range(0, 4) == 0) begin
        core_rsp_valid = 1; core_dout = rand_blk();
      end
      if (stall3) begin
        core_ready = (stall_cnt >= 3);
        if (core_valid && stall_cnt < 3) stall_cnt++;
      end else if (zero_wait) core_ready = 1;
      else core_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (core_valid) begin
        if (was_stalled) check("core_din_stable", MW'(core_din), MW'(held_din));
        if (core_ready) begin
          check("core_key", MW'(core_key), MW'(cur_key));
          check("core_dec", MW'(core_dec), MW'(cur_dec));
          pend = 1;
          pend_dout = core_dec ? toy_dec(core_key, core_din) : toy_enc(core_key, core_din);
          if (dly_force >= 0) pend_dly = dly_force;
          else if (zero_wait || stall3) pend_dly = 0;
          else pend_dly = $urandom_range(0, 3);
          stall_cnt = 0; was_stalled = 0; hs_count++;
        end else begin
          was_stalled = 1; held_din = core_din;
        end
      end
    end
  end

  initial begin
    rsp_ready = 0;
    forever begin
      @(posedge clk); #1;
      rsp_ready = rsp_force_en ? rsp_force : ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: every consumed response is compared against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("rsp_unexpected", MW'(1), MW'(0));
        else check("rsp_data", rsp_data, exp_q.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send_req(input bit dec, input bit cbc, input logic [KW-1:0] key,
                          input logic [BW-1:0] iv, input logic [MW-1:0] text);
    bit acc = 0;
    int n = 0;
    req_valid = 1; req_dec = dec; req_cbc = cbc; req_key = key; req_iv = iv; req_text = text;
    while (!acc && n < 300) begin
      @(negedge clk);
      if (req_ready) acc = 1;
      @(posedge clk); #1;
      n++;
    end
    req_valid = 0;
    if (!acc) check("req_accept_timeout", MW'(0), MW'(1));
    else begin
      exp_q.push_back(model(dec, cbc, key, iv, text));
      cur_key = key; cur_dec = dec;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) check("idle_timeout", MW'(0), MW'(1));
  endtask

  task automatic measure_latency(input string name, input int expected);
    int lat = 1;
    bit seen = 0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      if (lat == 1) check({name, "_core_valid_c1"}, MW'(core_valid), MW'(1));
      if (rsp_valid) seen = 1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    check(name, MW'(lat), MW'(expected));
  endtask

  initial begin
    logic [KW-1:0] key;
    logic [MW-1:0] pt, snap, text_b;
    bit ok;
    int n;
    rst_n = 1; req_valid = 0; req_dec = 0; req_cbc = 0;
    req_key = '0; req_iv = '0; req_text = '0;
    #1 rst_n = 0;
    #1;
    check("rst_req_ready", MW'(req_ready), MW'(0));
    check("rst_core_valid", MW'(core_valid), MW'(0));
    check("rst_rsp_valid", MW'(rsp_valid), MW'(0));
    check("rst_busy", MW'(busy), MW'(0));
    check("rst_rsp_data", rsp_data, MW'(0));
    check("rst_core_din", MW'(core_din), MW'(0));
    check("rst_core_key", MW'(core_key), MW'(0));
    check("rst_core_dec", MW'(core_dec), MW'(0));
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("idle_req_ready", MW'(req_ready), MW'(1));

    // Zero-wait encrypt, then decrypt with three stall cycles per block.
    zero_wait = 1; rsp_force_en = 1; rsp_force = 1;
    key = rand_blk(); pt = rand_msg();
    @(posedge clk); #1;
    send_req(0, 0, key, '0, pt);
    measure_latency("lat_zero_wait", 2 * NB + 1);
    wait_idle();
    zero_wait = 0; stall3 = 1;
    send_req(1, 0, key, '0, model(0, 0, key, '0, pt));
    measure_latency("lat_stall3", 5 * NB + 1);
    wait_idle();
    check("roundtrip_plaintext", rsp_data, pt);
    stall3 = 0;

    // Randomised traffic with stray core pulses and random back-pressure.
    spur_en = 1; rsp_force_en = 0;
    for (int i = 0; i < 24; i++) begin
      send_req($urandom_range(0, 1), $urandom_range(0, 1), rand_blk(), rand_blk(), rand_msg());
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    wait_idle();

    // Held response blocks the next request until one cycle after rsp_ready.
    spur_en = 0; zero_wait = 1; rsp_force_en = 1; rsp_force = 0;
    @(posedge clk); #1;
    send_req(0, 0, rand_blk(), '0, rand_msg());
    n = 0;
    while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("bp_reach_done", MW'(rsp_valid), MW'(1));
    snap = rsp_data; text_b = rand_msg(); key = rand_blk();
    req_valid = 1; req_dec = 0; req_cbc = 0; req_key = key; req_iv = '0; req_text = text_b;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", MW'(rsp_valid), MW'(1));
      check("bp_rsp_data", rsp_data, snap);
      check("bp_req_ready", MW'(req_ready), MW'(0));
    end
    rsp_force = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_req_ready_release", MW'(req_ready), MW'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_req_ready_next", MW'(req_ready), MW'(1));
    exp_q.push_back(model(0, 0, key, '0, text_b));
    cur_key = key; cur_dec = 0;
    @(posedge clk); #1;
    req_valid = 0;
    wait_idle();

    // Reset while waiting on block 1; the late core pulse must be ignored.
    zero_wait = 1; dly_force = 6;
    n = hs_count;
    send_req(0, 0, rand_blk(), '0, rand_msg());
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk); #2;
      if (hs_count == n + 2) ok = 1;
    end
    check("midop_reach_wait", MW'(ok), MW'(1));
    rst_n = 0;
    #1;
    check("midop_core_valid", MW'(core_valid), MW'(0));
    check("midop_busy", MW'(busy), MW'(0));
    check("midop_req_ready", MW'(req_ready), MW'(0));
    check("midop_rsp_data", rsp_data, MW'(0));
    check("midop_core_key", MW'(core_key), MW'(0));
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1;
    dly_force = -1;
    repeat (10) @(negedge clk);
    check("late_rsp_busy", MW'(busy), MW'(0));
    check("late_rsp_data", rsp_data, MW'(0));
    @(posedge clk); #1;
    send_req(0, 0, rand_blk(), '0, rand_msg());
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    check("global_timeout", MW'(0), MW'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_block_sequencer.md
# aes_block_sequencer

Clocked, parametrised sequencer that splits a multi-block message into BLK_W-bit blocks. It drives each block through a single external block-cipher core using valid/ready handshakes, then returns the reassembled result. It replaces the level-triggered AES ECB encrypt/decrypt adaptors in the testbench top with a cycle-accurate, back-pressurable block. The cipher core behind it is either the Python AES model bound via $pyvpi_main or a synthesizable core.

## Interface
Parameters:
- NUM_BLK, 2, number of blocks per request (≥1)
- BLK_W, 128, cipher block width in bits
- KEY_W, 128, key width in bits

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_dec  in  1  0 = encrypt, 1 = decrypt
- req_cbc  in  1  1 = CBC chaining (honoured only with AES_SEQ_CBC_EN)
- req_key  in  KEY_W  key
- req_iv  in  BLK_W  CBC initial vector
- req_text  in  NUM_BLK*BLK_W  input message; block 0 = most significant BLK_W bits
- core_valid  out  1  block issued to core
- core_ready  in  1  core accepts block
- core_dec  out  1  core direction
- core_key  out  KEY_W  core key
- core_din  out  BLK_W  core input block
- core_rsp_valid  in  1  core result valid, single-cycle pulse, no back-pressure
- core_dout  in  BLK_W  core result block
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  NUM_BLK*BLK_W  output message, same block ordering as req_text
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states:
  - IDLE: req_ready=1. On req_valid&req_ready, capture dec, cbc, key, iv and text; clear the block index; go to ISSUE.
  - ISSUE: core_valid=1. core_din, core_key and core_dec are held stable until core_ready. On core_valid&core_ready, go to WAIT.
  - WAIT: on core_rsp_valid, write the result block at index idx into rsp_data. Then go to DONE if idx==NUM_BLK-1; otherwise increment idx and go to ISSUE.
  - DONE: rsp_valid=1. rsp_data is stable. On rsp_ready, go to IDLE.
- Only one block is outstanding at a time.
- core_rsp_valid outside WAIT is ignored, including a pulse in the same cycle as the ISSUE handshake.
- The block index is $clog2(NUM_BLK) bits wide, minimum 1. It never wraps, because DONE is entered at NUM_BLK-1.
- rsp_data keeps the last completed result in IDLE. It is overwritten block by block during the next request.
- ECB mode: core_din = block idx of req_text; result = core_dout.

## Timing
- Reset values: req_ready=0 while rst_n low, then 1 in IDLE. core_valid, core_dec, core_key, core_din, rsp_valid, rsp_data and busy all reset to 0.
- Request accepted in cycle 0 → core_valid in cycle 1.
- Latency with a zero-wait core (core_ready=1, core_rsp_valid in the cycle after the handshake): rsp_valid asserts in cycle 2*NUM_BLK+1.
- Each core_ready stall cycle and each core response delay cycle adds one cycle to the latency.
- Reset mid-operation: return to IDLE immediately and drop any pending core_valid. A core response arriving after reset is ignored.
- req_valid is ignored outside IDLE. rsp_valid held without rsp_ready blocks acceptance of the next request.

## Configuration
- AES_SEQ_CBC_EN defined: req_cbc=1 selects CBC. A prev register holds C_{i-1}; it starts at req_iv.
  - Encrypt: core_din = P_i ^ prev; result C_i = core_dout; prev ← C_i.
  - Decrypt: core_din = C_i; result = core_dout ^ prev; prev ← C_i.
  - Latency is unchanged.
- AES_SEQ_CBC_EN undefined: no prev register is built. req_cbc and req_iv are ignored and every request runs ECB.

## Test plan
All vectors use key 2b7e151628aed2a6abf7158809cf4f3c with the AES model on the core port.
- ECB encrypt: NUM_BLK=2, text 6bc1bee22e409f96e93d7e117393172a_ae2d8a571e03ac9c9eb76fac45af8e51 → rsp_data 3ad77bb40d7a3660a89ecaf32466ef97_f5d3d58503b9699de785895a96fdbaaf; rsp_valid in cycle 5.
- ECB decrypt: the previous rsp_data with req_dec=1 → the original plaintext. Add core_ready low for 3 cycles per block → rsp_valid in cycle 11, and core_din stable throughout each stall.
- CBC (AES_SEQ_CBC_EN): iv 000102030405060708090a0b0c0d0e0f, same plaintext, encrypt → 7649abac8119b246cee98e9b12e9197d_5086cb9b507219ee95db113a917678b2. Decrypt of that result → the plaintext.
- Back-pressure: rsp_ready low for 10 cycles → rsp_valid and rsp_data held, req_ready=0, and a second req_valid is not accepted until 1 cycle after rsp_ready.
- Reset mid-op: assert rst_n low while in WAIT of block 1 → all outputs 0 asynchronously. A late core_rsp_valid is ignored, and the next request produces correct ECB vectors.
- Spurious response: a core_rsp_valid pulse while in ISSUE → ignored, with no change to the block index or rsp_data.
